dmem_responder: RTL and testbench

Data-memory responder: the target end of the core's DMEM interface (daddr, ddata_w, MemRead, MemWrite, ddata_r). It holds a word array and serves RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW accesses with a configurable wait-state latency. It returns a busy stall to the pipeline, a one-cycle completion strobe, and an error flag for illegal accesses.

---
 rtl/dmem_pkg.sv | 16 +
 rtl/dmem_lane_align.sv | 59 +++++
 rtl/dmem_responder.sv | 139 +++++++++++++
 tb/tb_dmem_responder.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder.
// funct3 access encodings and the FSM state type.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } dmem_state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane extract/extend for loads, lane merge for stores,
// and detection of misaligned or undefined funct3 accesses.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0] word_old,
  input  logic [DW-1:0] wdata,
  input  logic [2:0]    funct3,
  input  logic [1:0]    off,
  input  logic          is_store,
  output logic [DW-1:0] rdata,
  output logic [DW-1:0] wword,
  output logic          misalign,
  output logic          illegal
);

  logic [7:0]  b;
  logic [15:0] h;

  assign b = word_old[{off, 3'b000} +: 8];
  assign h = off[1] ? word_old[31:16] : word_old[15:0];

  // Load result, extended to the bus width
  always_comb begin
    rdata = '0;
    case (funct3)
      F3_B:  rdata = {{(DW-8){b[7]}}, b};
      F3_BU: rdata = {{(DW-8){1'b0}}, b};
      F3_H:  rdata = {{(DW-16){h[15]}}, h};
      F3_HU: rdata = {{(DW-16){1'b0}}, h};
      F3_W:  rdata = word_old;
      default: rdata = '0;
    endcase
  end

  // Store merge: only the addressed lanes change
  always_comb begin
    wword = word_old;
    case (funct3[1:0])
      2'b00: wword[{off, 3'b000} +: 8] = wdata[7:0];
      2'b01: wword[{off[1], 4'b0000} +: 16] = wdata[15:0];
      2'b10: wword = wdata;
      default: wword = word_old;
    endcase
  end

  // Alignment and encoding checks
  always_comb begin
    misalign = ((funct3[1:0] == 2'b01) & off[0]) |
               ((funct3[1:0] == 2'b10) & (off != 2'b00));
    if (is_store)
      illegal = (funct3 >= 3'b011);
    else
      illegal = (funct3 == 3'b011) | (funct3[2:1] == 2'b11);
  end

endmodule

// File: rtl/dmem_responder.sv
// DMEM target: word array serving RISC-V loads/stores with
// WAIT_CYCLES wait states, busy stall, done and err pulses.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int data_size    = 1024,
  parameter int address_size = 32,
  parameter int WAIT_CYCLES  = 2
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic [address_size-1:0] daddr,
  input  logic [address_size-1:0] ddata_w,
  input  logic                    MemRead,
  input  logic                    MemWrite,
  input  logic [2:0]              funct3,
  output logic [address_size-1:0] ddata_r,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int IW = $clog2(data_size);
  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_CYCLES);
  localparam logic HAS_WAIT = (WAIT_CYCLES > 0);

  logic [address_size-1:0] mem [data_size];

  dmem_state_t             state;
  logic [CW-1:0]           cnt;
  logic [address_size-1:0] a_q;
  logic [address_size-1:0] wd_q;
  logic [2:0]              f3_q;
  logic                    st_q;
  logic                    both_q;

  logic                    req;
  logic                    live;
  logic [address_size-1:0] cur_a;
  logic [address_size-1:0] cur_wd;
  logic [2:0]              cur_f3;
  logic                    cur_st;
  logic                    cur_both;
  logic                    fire;
  logic [IW-1:0]           idx;
  logic                    oor;
  logic [address_size-1:0] old_word;
  logic [address_size-1:0] rdata;
  logic [address_size-1:0] wword;
  logic                    misalign;
  logic                    illegal;
  logic                    bad;
  logic                    err_c;

  assign req  = MemRead | MemWrite;
  assign live = (state == IDLE);

  // In IDLE the live request is the access (zero-wait path);
  // in WAIT only the latched copy is used.
  assign cur_a    = live ? daddr    : a_q;
  assign cur_wd   = live ? ddata_w  : wd_q;
  assign cur_f3   = live ? funct3   : f3_q;
  assign cur_st   = live ? MemWrite : st_q;
  assign cur_both = live ? (MemRead & MemWrite) : both_q;

  assign fire = live ? (req & ~HAS_WAIT) : (cnt == CW'(1));

  assign idx = cur_a[IW+1:2];
  assign oor = {2'b00, cur_a[address_size-1:2]} >=
               address_size'(data_size);
  assign old_word = mem[idx];

  dmem_lane_align #(
    .DW(address_size)
  ) u_align (
    .word_old(old_word),
    .wdata   (cur_wd),
    .funct3  (cur_f3),
    .off     (cur_a[1:0]),
    .is_store(cur_st),
    .rdata   (rdata),
    .wword   (wword),
    .misalign(misalign),
    .illegal (illegal)
  );

  assign bad   = misalign | illegal | oor;
  assign err_c = bad | cur_both;

  assign busy = (live & req & HAS_WAIT) | (state == WAIT);

  // Request latch, wait counter and completion outputs
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= IDLE;
      cnt     <= '0;
      a_q     <= '0;
      wd_q    <= '0;
      f3_q    <= '0;
      st_q    <= 1'b0;
      both_q  <= 1'b0;
      ddata_r <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= fire;
      err  <= fire & err_c;
      if (fire & ~cur_st)
        ddata_r <= err_c ? '0 : rdata;
      unique case (state)
        IDLE: begin
          if (req) begin
            a_q    <= daddr;
            wd_q   <= ddata_w;
            f3_q   <= funct3;
            st_q   <= MemWrite;
            both_q <= MemRead & MemWrite;
            cnt    <= CNT_INIT;
            if (HAS_WAIT)
              state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1))
            state <= IDLE;
        end
      endcase
    end
  end

  // Array write; contents are deliberately not reset
  always_ff @(posedge CLK) begin
    if (RESET_N && fire && cur_st && !bad)
      mem[idx] <= wword;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a 2-wait instance for
// access/extend/error/reset cases, a 0-wait one for back-to-back.
module tb_dmem_responder;

  logic        CLK;
  logic        RESET_N;

  logic [31:0] daddr, ddata_w, ddata_r;
  logic        MemRead, MemWrite, busy, done, err;
  logic [2:0]  funct3;

  logic [31:0] daddr1, ddata_w1, ddata_r1;
  logic        MemRead1, MemWrite1, busy1, done1, err1;
  logic [2:0]  funct31;

  int errors = 0;
  int checks = 0;

  dmem_responder #(
    .data_size(1024), .address_size(32), .WAIT_CYCLES(2)
  ) u0 (
    .CLK(CLK), .RESET_N(RESET_N), .daddr(daddr),
    .ddata_w(ddata_w), .MemRead(MemRead), .MemWrite(MemWrite),
    .funct3(funct3), .ddata_r(ddata_r), .busy(busy),
    .done(done), .err(err)
  );

  dmem_responder #(
    .data_size(1024), .address_size(32), .WAIT_CYCLES(0)
  ) u1 (
    .CLK(CLK), .RESET_N(RESET_N), .daddr(daddr1),
    .ddata_w(ddata_w1), .MemRead(MemRead1), .MemWrite(MemWrite1),
    .funct3(funct31), .ddata_r(ddata_r1), .busy(busy1),
    .done(done1), .err(err1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One access on u0; returns result, err and cycles to done
  task automatic access(input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] f3,
                        output logic [31:0] r, output logic e,
                        output int lat);
    @(posedge CLK); #1;
    MemRead = rd; MemWrite = wr;
    daddr = a; ddata_w = d; funct3 = f3;
    @(posedge CLK); #1;
    MemRead = 1'b0; MemWrite = 1'b0;
    lat = 0; r = 'x; e = 1'bx;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(negedge CLK);
      if (done === 1'b1) begin
        lat = k; r = ddata_r; e = err;
      end
    end
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    MemRead = 0; MemWrite = 0; daddr = 0; ddata_w = 0; funct3 = 0;
    MemRead1 = 0; MemWrite1 = 0; daddr1 = 0; ddata_w1 = 0; funct31 = 0;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if ({ddata_r, busy, done, err} !== 35'h0) begin
      errors++;
      $display("FAIL reset_u0 got %h want 0", {ddata_r, busy, done, err});
    end
    checks++;
    if ({ddata_r1, busy1, done1, err1} !== 35'h0) begin
      errors++;
      $display("FAIL reset_u1 got %h want 0", {ddata_r1, busy1, done1, err1});
    end
    @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  task automatic test_store_load();
    logic [31:0] r; logic e, b_done; int lat;
    @(posedge CLK); #1;
    MemWrite = 1'b1; daddr = 32'h10; ddata_w = 32'hDEADBEEF;
    funct3 = 3'b010;
    @(negedge CLK);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL busy_req got %b want 1", busy);
    end
    @(posedge CLK); #1;
    MemWrite = 1'b0;
    lat = 0; e = 1'bx; b_done = 1'bx;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(negedge CLK);
      if (done === 1'b1) begin
        lat = k; e = err; b_done = busy;
      end
    end
    checks++;
    if (lat != 3) begin
      errors++; $display("FAIL sw_latency got %0d want 3", lat);
    end
    checks++;
    if ({e, b_done} !== 2'b00) begin
      errors++; $display("FAIL sw_err_busy got %b want 00", {e, b_done});
    end
    access(1, 0, 32'h10, 0, 3'b010, r, e, lat);
    checks++;
    if ({e, r} !== {1'b0, 32'hDEADBEEF} || lat != 3) begin
      errors++;
      $display("FAIL lw_10 got %b %h lat %0d want 0 deadbeef lat 3", e, r, lat);
    end
  endtask

  task automatic test_extension();
    logic [31:0] ad [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
    logic [2:0]  fs [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] ex [4] = '{32'hFFFFFFDE, 32'h000000DE,
                            32'hFFFFDEAD, 32'h0000BEEF};
    logic [31:0] r; logic e; int lat;
    for (int i = 0; i < 4; i++) begin
      access(1, 0, ad[i], 0, fs[i], r, e, lat);
      checks++;
      if ({e, r} !== {1'b0, ex[i]}) begin
        errors++;
        $display("FAIL ext_%0d got %b %h want 0 %h", i, e, r, ex[i]);
      end
    end
  endtask

  task automatic test_partial_store();
    logic [31:0] r; logic e; int lat;
    access(0, 1, 32'h11, 32'h00000055, 3'b000, r, e, lat);
    access(1, 0, 32'h10, 0, 3'b010, r, e, lat);
    checks++;
    if (r !== 32'hDEAD55EF) begin
      errors++; $display("FAIL sb_11 got %h want dead55ef", r);
    end
    access(0, 1, 32'h12, 32'h00001234, 3'b001, r, e, lat);
    access(1, 0, 32'h10, 0, 3'b010, r, e, lat);
    checks++;
    if (r !== 32'h123455EF) begin
      errors++; $display("FAIL sh_12 got %h want 123455ef", r);
    end
  endtask

  task automatic test_errors();
    logic [31:0] r; logic e; int lat;
    access(1, 0, 32'h12, 0, 3'b010, r, e, lat);
    checks++;
    if ({e, r} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL lw_misalign got %b %h want 1 0", e, r);
    end
    access(0, 1, 32'h11, 32'h0000FFFF, 3'b001, r, e, lat);
    checks++;
    if (e !== 1'b1) begin
      errors++; $display("FAIL sh_misalign_err got %b want 1", e);
    end
    access(1, 0, 32'h10, 0, 3'b010, r, e, lat);
    checks++;
    if ({e, r} !== {1'b0, 32'h123455EF}) begin
      errors++; $display("FAIL sh_misalign_mem got %b %h want 0 123455ef", e, r);
    end
    access(1, 0, 32'h1000, 0, 3'b010, r, e, lat);
    checks++;
    if ({e, r} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL lw_range got %b %h want 1 0", e, r);
    end
    access(1, 0, 32'h10, 0, 3'b011, r, e, lat);
    checks++;
    if ({e, r} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL ld_f3_011 got %b %h want 1 0", e, r);
    end
    access(0, 1, 32'h10, 32'h0, 3'b011, r, e, lat);
    checks++;
    if (e !== 1'b1) begin
      errors++; $display("FAIL st_f3_011 got %b want 1", e);
    end
    access(1, 0, 32'h10, 0, 3'b010, r, e, lat);
    checks++;
    if ({e, r} !== {1'b0, 32'h123455EF}) begin
      errors++; $display("FAIL st_f3_mem got %b %h want 0 123455ef", e, r);
    end
  endtask

  task automatic test_both();
    logic [31:0] r; logic e; int lat;
    access(1, 1, 32'h10, 32'h0BADF00D, 3'b010, r, e, lat);
    checks++;
    if ({e, r} !== {1'b1, 32'h123455EF}) begin
      errors++; $display("FAIL both_err got %b %h want 1 123455ef", e, r);
    end
    access(1, 0, 32'h10, 0, 3'b010, r, e, lat);
    checks++;
    if ({e, r} !== {1'b0, 32'h0BADF00D}) begin
      errors++; $display("FAIL both_mem got %b %h want 0 0badf00d", e, r);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] r; logic e; int lat;
    access(0, 1, 32'h20, 32'h0, 3'b010, r, e, lat);
    @(posedge CLK); #1;
    MemWrite = 1'b1; daddr = 32'h20; ddata_w = 32'hA5A5A5A5;
    funct3 = 3'b010;
    @(posedge CLK); #1;
    MemWrite = 1'b0;
    @(negedge CLK);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL mid_wait_busy got %b want 1", busy);
    end
    #2 RESET_N = 1'b0;
    #1;
    checks++;
    if ({ddata_r, busy, done, err} !== 35'h0) begin
      errors++;
      $display("FAIL reset_async got %h want 0", {ddata_r, busy, done, err});
    end
    @(negedge CLK);
    RESET_N = 1'b1;
    access(1, 0, 32'h20, 0, 3'b010, r, e, lat);
    checks++;
    if ({e, r} !== {1'b0, 32'h0}) begin
      errors++; $display("FAIL reset_store_dropped got %b %h want 0 0", e, r);
    end
  endtask

  task automatic test_zero_wait();
    @(posedge CLK); #1;
    MemWrite1 = 1'b1; daddr1 = 32'h4; ddata_w1 = 32'hCAFEF00D;
    funct31 = 3'b010;
    @(negedge CLK);
    checks++;
    if ({busy1, done1} !== 2'b00) begin
      errors++; $display("FAIL w0_sw_req got %b want 00", {busy1, done1});
    end
    @(posedge CLK); #1;
    MemWrite1 = 1'b0; MemRead1 = 1'b1;
    @(negedge CLK);
    checks++;
    if ({busy1, done1, err1} !== 3'b010) begin
      errors++;
      $display("FAIL w0_sw_done got %b want 010", {busy1, done1, err1});
    end
    @(posedge CLK); #1;
    MemRead1 = 1'b0;
    @(negedge CLK);
    checks++;
    if ({busy1, done1, err1, ddata_r1} !== {3'b010, 32'hCAFEF00D}) begin
      errors++;
      $display("FAIL w0_lw_done got %b %h want 010 cafef00d",
               {busy1, done1, err1}, ddata_r1);
    end
    @(negedge CLK);
    checks++;
    if (done1 !== 1'b0) begin
      errors++; $display("FAIL w0_done_drop got %b want 0", done1);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_extension();
    test_partial_store();
    test_errors();
    test_both();
    test_reset_mid_wait();
    test_zero_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
